// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
package calc_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BCD_DIGITS   = 4;
  localparam int MAX_DISPLAY  = 9999;
  localparam int BCD_NIBBLE_W = 4;
  localparam int BCD_W        = BCD_DIGITS * BCD_NIBBLE_W;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: nibbles of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import calc_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] d_i,
  output logic [BCD_NIBBLE_W-1:0] d_o
);
  assign d_o = (d_i >= BCD_NIBBLE_W'(5)) ? d_i + BCD_NIBBLE_W'(3) : d_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (one shift-add-3 step per cycle).
// Input saturates at 9999; digits are held between conversions so the
// display scanner never sees a partially converted value.
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [3:0]           first_digit,
  output logic [3:0]           second_digit,
  output logic [3:0]           third_digit,
  output logic [3:0]           fourth_digit
);
  localparam int                   CNT_W = $clog2(BIN_WIDTH);
  localparam logic [BIN_WIDTH-1:0] SAT   = BIN_WIDTH'(MAX_DISPLAY);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(BIN_WIDTH - 1);

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] operand_q, operand_d;
  logic [BCD_W-1:0]     scratch_q, scratch_d;
  logic [BCD_W-1:0]     adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [BCD_W-1:0]     digits_q, digits_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  // Per-digit add-3 correction applied to the scratch register
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (scratch_q[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .d_o (adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath next values; everything holds unless a state acts
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          operand_d = (bin_in > SAT) ? SAT : bin_in;
          pend_d    = (bin_in > SAT);
          scratch_d = '0;
          cnt_d     = '0;
        end
      end
      SHIFT: begin
        // Corrected scratch and operand shift left together as one word
        scratch_d = {adj[BCD_W-2:0], operand_q[BIN_WIDTH-1]};
        operand_d = {operand_q[BIN_WIDTH-2:0], 1'b0};
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE: begin
        digits_d = scratch_q;
        ovf_d    = pend_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      operand_q <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      operand_q <= operand_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign first_digit  = digits_q[3:0];
  assign second_digit = digits_q[7:4];
  assign third_digit  = digits_q[11:8];
  assign fourth_digit = digits_q[15:12];
endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-add-3 / double-dabble) feeding the four-digit display path of the calculator. It takes the unsigned binary result from the arithmetic unit on a start/done handshake and produces four registered BCD digits. Those digits stay stable between conversions so the display multiplexer can scan them continuously without tearing.

## Interface
- `BIN_WIDTH`, 14: width of the binary input; must be ≥ 14 so the saturation value 9999 is representable.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a conversion of `bin_in`; sampled only in IDLE.
- `bin_in`  in  BIN_WIDTH  unsigned binary value to convert.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse: new digits valid.
- `overflow`  out  1  last converted value exceeded 9999; held until the next conversion completes.
- `first_digit`  out  4  ones digit (BCD).
- `second_digit`  out  4  tens digit.
- `third_digit`  out  4  hundreds digit.
- `fourth_digit`  out  4  thousands digit.

## Operation
- FSM states:
  - IDLE: if `start`, capture the operand and go to SHIFT. Otherwise stay.
  - SHIFT: one iteration per cycle. After iteration BIN_WIDTH−1, go to DONE.
  - DONE: load the output registers, pulse `done`, return to IDLE.
- Capture: the operand register gets `min(bin_in, 9999)`. A pending-overflow bit gets `(bin_in > 9999)`. The BCD scratch register (16 bits) and iteration counter are cleared.
- Iteration in SHIFT, in one cycle:
  - For each scratch nibble ≥ 5, add 3 (nibble arithmetic, no carry between nibbles).
  - Then shift {scratch, operand} left by 1, so the operand MSB enters scratch bit 0.
- Counter width is $clog2(BIN_WIDTH). It counts 0..BIN_WIDTH−1 and does not wrap past that.
- DONE:
  - Digit outputs get scratch[3:0], [7:4], [11:8], [15:12] (ones..thousands).
  - `overflow` gets the pending-overflow bit.
- Outputs change only on the DONE edge and hold otherwise.
- `start` while busy (SHIFT/DONE) is ignored. It is not queued and has no effect on the conversion in progress.
- `bin_in` is only sampled at capture; later changes do not matter.
- Reset values:
  - state IDLE, `busy` 0, `done` 0, `overflow` 0.
  - All digits 0, scratch 0, counter 0.
- Reset mid-conversion aborts the conversion. Outputs return to their reset values and no `done` is produced.

## Timing
- Start accepted at edge E0 (IDLE, `start`=1).
- `busy` is high from after E0 until after E(BIN_WIDTH+1).
- SHIFT iterations occur at edges E1..E(BIN_WIDTH). The DONE actions occur at edge E(BIN_WIDTH+1), which is E15 for the default.
- Digits and `overflow` update and `done`=1 in the cycle after E15. `busy` is already 0 in that cycle.
- `done` is exactly one cycle wide.
- A `start` in the `done`-high cycle is accepted (state is IDLE), so back-to-back throughput is one conversion per BIN_WIDTH+2 cycles.
- `busy` is decoded from the state register, with no extra latency.

## Structure
- Shared package `calc_pkg`:
  - FSM state enum (IDLE, SHIFT, DONE).
  - `BCD_DIGITS`=4.
  - `MAX_DISPLAY`=9999.
  - `BCD_NIBBLE_W`=4.
- Sub-module `bcd_add3`: combinational 4-bit cell, out = (in ≥ 5) ? in+3 : in. Instantiate it BCD_DIGITS times on the scratch register.
- Top level holds the FSM, counter, operand/scratch shift registers and output registers.

## Test plan
- `bin_in`=1234, `start` pulse:
  - After 15 cycles, `done`=1 for 1 cycle.
  - Digits fourth..first = 1,2,3,4; `overflow`=0; `busy` high for exactly 15 cycles.
- `bin_in`=0, then `bin_in`=9999 back-to-back, with `start` reasserted in the `done` cycle:
  - First result is 0,0,0,0. Second is 9,9,9,9.
  - Second `done` comes 16 cycles after the first.
- `bin_in`=10000: digits 9,9,9,9 and `overflow`=1. A following `bin_in`=42 gives 0,0,4,2 and clears `overflow`.
- Start 1234, then pulse `start` with `bin_in`=5678 at cycle 5 while busy: result 1,2,3,4 and only one `done`.
- Start 5678, then assert `reset` at cycle 7:
  - No `done`; all digits 0; `busy`=0 next cycle.
  - A subsequent start with 5678 yields 5,6,7,8.
- Previous result 8,8,8,8, then start 0001 and change `bin_in` during SHIFT: digits stay 8,8,8,8 until the DONE edge, then become 0,0,0,1.
